// File: rtl/keypad_pkg.sv
// Shared types and sizing helpers for the keypad scanner.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESS,
        ST_HOLD,
        ST_RELEASE
    } keypad_state_t;

    // Index width that never collapses to zero bits for a count of one.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keypad_scan_next_state.sv
// Next-state, row-advance and counter decode for the keypad scanner FSM.
module keypad_scan_next_state
    import keypad_pkg::*;
#(
    parameter int NROWS           = 4,
    parameter int NCOLS           = 4,
    parameter int SETTLE_CYCLES   = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int RW   = idx_w(NROWS),
    localparam int CW   = idx_w(NCOLS),
    localparam int MAXC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES,
    localparam int CNTW = idx_w(MAXC)
) (
    input  keypad_state_t    state,
    input  logic [RW-1:0]    r,
    input  logic [CNTW-1:0]  cnt,
    input  logic [CW-1:0]    c,
    input  logic [NCOLS-1:0] cols_s,
    output keypad_state_t    state_nxt,
    output logic [RW-1:0]    r_nxt,
    output logic [CNTW-1:0]  cnt_nxt,
    output logic [CW-1:0]    c_nxt,
    output logic             load_code,
    output logic             key_valid,
    output logic             key_held,
    output logic             key_release
);

    localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE_CYCLES - 1);
    localparam logic [CNTW-1:0] DEB_LAST    = CNTW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0]   R_LAST      = RW'(NROWS - 1);

    logic [RW-1:0] r_adv;
    logic [CW-1:0] low_col;
    logic          c_high;

    // Descending walk so the lowest set column is the last one written.
    always_comb begin
        low_col = '0;
        for (int i = NCOLS - 1; i >= 0; i--) begin
            if (cols_s[i]) low_col = CW'(i);
        end
    end

    assign r_adv  = (r == R_LAST) ? '0 : r + RW'(1);
    assign c_high = cols_s[c];

    always_comb begin
        state_nxt   = state;
        r_nxt       = r;
        cnt_nxt     = cnt;
        c_nxt       = c;
        load_code   = 1'b0;
        key_valid   = 1'b0;
        key_held    = 1'b0;
        key_release = 1'b0;
        unique case (state)
            ST_SCAN: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_nxt = '0;
                    if (cols_s == '0) begin
                        r_nxt = r_adv;
                    end else begin
                        c_nxt     = low_col;
                        state_nxt = ST_DEBOUNCE;
                    end
                end else begin
                    cnt_nxt = cnt + CNTW'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (!c_high) begin
                    state_nxt = ST_SCAN;
                    r_nxt     = r_adv;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = ST_PRESS;
                    cnt_nxt   = '0;
                    load_code = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNTW'(1);
                end
            end
            ST_PRESS: begin
                key_valid = 1'b1;
                key_held  = 1'b1;
                state_nxt = ST_HOLD;
            end
            // Row stays frozen here; only the captured column is watched.
            ST_HOLD: begin
                key_held = 1'b1;
                if (!c_high) begin
                    state_nxt = ST_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            ST_RELEASE: begin
                key_held = 1'b1;
                if (c_high) begin
                    state_nxt = ST_HOLD;
                end else if (cnt == DEB_LAST) begin
                    key_release = 1'b1;
                    state_nxt   = ST_SCAN;
                    r_nxt       = r_adv;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + CNTW'(1);
                end
            end
            default: state_nxt = ST_SCAN;
        endcase
    end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning matrix keypad controller with column synchronizer and debounce.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int NROWS           = 4,
    parameter int NCOLS           = 4,
    parameter int SETTLE_CYCLES   = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int KW = idx_w(NROWS * NCOLS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCOLS-1:0] cols,
    output logic [NROWS-1:0] rows,
    output logic             key_valid,
    output logic [KW-1:0]    key_code,
    output logic             key_held,
    output logic             key_release
);

    localparam int RW   = idx_w(NROWS);
    localparam int CW   = idx_w(NCOLS);
    localparam int MAXC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNTW = idx_w(MAXC);

    logic [NCOLS-1:0] cols_p0, cols_p1;
    keypad_state_t    state, state_nxt;
    logic [RW-1:0]    r, r_nxt;
    logic [CNTW-1:0]  cnt, cnt_nxt;
    logic [CW-1:0]    c, c_nxt;
    logic             load_code;
    logic [KW-1:0]    code_nxt;

    // Stage p0/p1: two-flop synchronizer for the asynchronous column lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cols_p0 <= '0;
            cols_p1 <= '0;
        end else begin
            cols_p0 <= cols;
            cols_p1 <= cols_p0;
        end
    end

    keypad_scan_next_state #(
        .NROWS          (NROWS),
        .NCOLS          (NCOLS),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_next (
        .state      (state),
        .r          (r),
        .cnt        (cnt),
        .c          (c),
        .cols_s     (cols_p1),
        .state_nxt  (state_nxt),
        .r_nxt      (r_nxt),
        .cnt_nxt    (cnt_nxt),
        .c_nxt      (c_nxt),
        .load_code  (load_code),
        .key_valid  (key_valid),
        .key_held   (key_held),
        .key_release(key_release)
    );

    assign code_nxt = KW'(r) * KW'(NCOLS) + KW'(c);

    // Code loads on the debounce->press edge so it is already valid during PRESS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_SCAN;
            r        <= '0;
            cnt      <= '0;
            c        <= '0;
            key_code <= '0;
        end else begin
            state <= state_nxt;
            r     <= r_nxt;
            cnt   <= cnt_nxt;
            c     <= c_nxt;
            if (load_code) key_code <= code_nxt;
        end
    end

    assign rows = NROWS'(1) << r;

endmodule
